// File: rtl/tx_buff_ctrl_pkg.sv
// Shared types and constants for the I2C transmit buffer controller.
package tx_buff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int WORD_W_DEF = 32;

endpackage

// File: rtl/tx_buff_ctrl_dbuf.sv
// Two-slot FIFO-ordered word buffer; slot s0 is always the oldest word.
module tx_dbuf
    import tx_buff_ctrl_pkg::*;
#(
    parameter int W = WORD_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] s0;
    logic [W-1:0] s1;

    assign head = s0;

    // Caller only pushes when count < 2 and only pops when count > 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            s0    <= '0;
            s1    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) s0 <= din;
                    else               s1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    s0    <= s1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        s0 <= din;
                    end else begin
                        s0 <= s1;
                        s1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tx_buff_ctrl.sv
// Transmit buffer controller feeding a serial shift register from a 2-word buffer.
// Define TX_BUFF_UNDERRUN_EN to add the sticky underrun flag and its clear input.
module tx_buff_ctrl
    import tx_buff_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              bit_req,
    output logic              load,
    output logic              shift,
    output logic [WORD_W-1:0] data_out,
    output logic              busy,
    output logic              tx_done
`ifdef TX_BUFF_UNDERRUN_EN
    ,
    output logic              underrun,
    input  logic              underrun_clr
`endif
);

    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_W);
    localparam logic [CW-1:0] PENULT = CW'(WORD_W - 1);

    state_t state;
    state_t state_n;

    logic [CW-1:0]     bit_cnt;
    logic [1:0]        count;
    logic [WORD_W-1:0] head;
    logic              push;
    logic              pop;
    logic              bit_ok;
    logic              fin;

    assign wr_ready = (count != 2'd2);
    assign push     = wr_en && wr_ready;
    assign pop      = (state == LOAD);
    assign bit_ok   = (state == SHIFT) && bit_req && (bit_cnt != LAST);
    assign fin      = shift && (bit_cnt == LAST);

    tx_dbuf #(.W(WORD_W)) u_dbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .count (count),
        .head  (head)
    );

    // tx_done is decided with the final bit request, so it already
    // tells us whether another word is waiting when the last shift shows.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (count != 2'd0) state_n = LOAD;
            LOAD:    state_n = SHIFT;
            SHIFT:   if (fin) state_n = tx_done ? IDLE : LOAD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            load     <= 1'b0;
            shift    <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state   <= state_n;
            load    <= (state_n == LOAD);
            busy    <= (state_n != IDLE);
            shift   <= bit_ok;
            tx_done <= bit_ok && (bit_cnt == PENULT)
                       && (count == 2'd0) && !push;
            if (state == LOAD)
                bit_cnt <= '0;
            else if (bit_ok)
                bit_cnt <= bit_cnt + 1'b1;
            if (state_n == LOAD)
                data_out <= head;
        end
    end

`ifdef TX_BUFF_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (rst || underrun_clr)
            underrun <= 1'b0;
        else if (bit_req && (state != SHIFT))
            underrun <= 1'b1;
    end
`endif

endmodule

// File: doc/tx_buff_ctrl.md
TX_BUFF_CTRL -- requirements
Module: tx_buff_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 32, bits per transmitted word.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  host write strobe; word accepted when wr_en and wr_ready are both high.
REQ-005 SHALL have port wr_data  input  WORD_W  host word to transmit.
REQ-006 SHALL have port wr_ready  output  1  high when buffer has a free slot.
REQ-007 SHALL have port bit_req  input  1  one-cycle strobe from the I2C bit timer requesting the next serial bit.
REQ-008 SHALL have port load  output  1  one-cycle pulse to the downstream shift register's load input.
REQ-009 SHALL have port shift  output  1  one-cycle pulse to the downstream shift register's shift input.
REQ-010 SHALL have port data_out  output  WORD_W  word presented to the downstream shift register's data input.
REQ-011 SHALL have port busy  output  1  high while a word is loaded or being shifted.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse when the last word is fully shifted and the buffer is empty.

Function
REQ-013 SHALL hold up to two words in a FIFO-ordered double buffer (slot count 0..2); wr_ready = (count < 2).
REQ-014 SHALL ignore wr_en while wr_ready is low; no overwrite, no count change.
REQ-015 SHALL implement states IDLE, LOAD, SHIFT, all outputs registered.
REQ-016 IDLE: when count > 0, next state is LOAD; otherwise stays IDLE with busy low.
REQ-017 LOAD (exactly one cycle): load = 1, data_out = oldest word, word popped, bit counter cleared to 0, next state SHIFT.
REQ-018 SHIFT: each bit_req asserts shift for exactly one cycle on the following cycle and increments the bit counter.
REQ-019 SHIFT: on the cycle the WORD_W-th shift is asserted, next state is LOAD if count > 0 (back-to-back, no idle gap), else IDLE with tx_done pulsed that cycle.
REQ-020 bit_req in IDLE or LOAD SHALL produce no shift and no counter change.
REQ-021 data_out SHALL hold its value from a load until the next load.
REQ-022 Simultaneous write and pop SHALL leave count unchanged; a write accepted while count = 1 during LOAD enqueues behind the popped word.
REQ-023 busy SHALL be high in LOAD and SHIFT states, low in IDLE.
REQ-024 Bit counter SHALL be ceil(log2(WORD_W+1)) bits wide and never exceed WORD_W.

Reset
REQ-025 rst high SHALL, on the next clock edge, force IDLE, count = 0, bit counter = 0, load = 0, shift = 0, data_out = 0, busy = 0, tx_done = 0, wr_ready = 1.
REQ-026 Reset during SHIFT SHALL abandon the current word and discard both buffered words.

Configuration
REQ-027 Macro TX_BUFF_UNDERRUN_EN, when defined, SHALL add output underrun (1 bit, sticky) and input underrun_clr (1 bit).
REQ-028 With TX_BUFF_UNDERRUN_EN defined, underrun SHALL set on a bit_req received in IDLE or LOAD and clear on underrun_clr or rst; clr wins over a simultaneous set.
REQ-029 Without TX_BUFF_UNDERRUN_EN, neither port exists and no underrun logic is synthesized.

Structure
REQ-030 Shared package SHALL hold the state enum (IDLE, LOAD, SHIFT) and the default word width constant 32.
REQ-031 The two-slot buffer SHALL be a sub-module tx_dbuf (push/pop/count/head) instantiated once.

Verification
REQ-032 Scenario: after reset, write 0xA5A5_0001, issue 32 bit_req -> one load with data_out = 0xA5A5_0001, 32 shift pulses, tx_done pulse, busy low.
REQ-033 Scenario: write 0x1111_1111, 0x2222_2222, 0x3333_3333 back-to-back -> third write blocked until first load; three loads in order, each exactly 32 shifts apart, no IDLE cycle between words.
REQ-034 Scenario: count = 2 with wr_en held -> wr_ready low, buffer contents unchanged.
REQ-035 Scenario: rst asserted after 10 shifts of 0xDEAD_BEEF with one word queued -> next cycle all outputs at reset values, no further load.
REQ-036 Scenario (TX_BUFF_UNDERRUN_EN): bit_req in IDLE -> underrun = 1 and no shift; underrun_clr together with another bit_req -> underrun = 0.
